// File: rtl/main.sv
// rtl/main.sv - registered modulo-11 adder/subtractor on 4-bit operands
module main (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic x3,
  input  logic x2,
  input  logic x1,
  input  logic x0,
  input  logic y3,
  input  logic y2,
  input  logic y1,
  input  logic y0,
  output logic z3,
  output logic z2,
  output logic z1,
  output logic z0
);

  localparam logic [3:0] MODULUS = 4'd11;

  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] xr;
  logic [3:0] yr;
  logic       carry;
  logic [3:0] sum4;
  logic [3:0] diff4;
  logic [3:0] res;
  logic [3:0] z_q;

  assign x = {x3, x2, x1, x0};
  assign y = {y3, y2, y1, y0};

  // Fold operand codes 11..15 back into the residue range 0..4
  always_comb begin
    xr = (x >= MODULUS) ? (x - MODULUS) : x;
    yr = (y >= MODULUS) ? (y - MODULUS) : y;
  end

  // Modular add/subtract done in 4-bit arithmetic; wrap mod 16 cancels out
  // because the corrected result always lands in 0..10
  always_comb begin
    {carry, sum4} = {1'b0, xr} + {1'b0, yr};
    diff4         = xr - yr;
    res           = '0;
    if (!s) begin
      if (carry || (sum4 >= MODULUS)) begin
        res = sum4 - MODULUS;
      end else begin
        res = sum4;
      end
    end else begin
      if (xr >= yr) begin
        res = diff4;
      end else begin
        res = diff4 + MODULUS;
      end
    end
  end

  // Single result register; synchronous reset clears it to zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q <= '0;
    end else begin
      z_q <= res;
    end
  end

  assign {z3, z2, z1, z0} = z_q;

endmodule

// File: tb/tb_main.sv
// tb/tb_main.sv - scoreboard bench for the modulo-11 adder/subtractor
module tb_main;

  logic       clk;
  logic       rst_n;
  logic       s;
  logic [3:0] x;
  logic [3:0] y;
  logic       z3, z2, z1, z0;
  logic [3:0] z;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_total;
  int   n_pass;

  main dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (s),
    .x3    (x[3]),
    .x2    (x[2]),
    .x1    (x[1]),
    .x0    (x[0]),
    .y3    (y[3]),
    .y2    (y[2]),
    .y1    (y[1]),
    .y0    (y[0]),
    .z3    (z3),
    .z2    (z2),
    .z1    (z1),
    .z0    (z0)
  );

  assign z = {z3, z2, z1, z0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: reduce mod 11, then add or subtract with a non-negative residue
  function automatic logic [3:0] ref_mod(input logic op, input int a, input int b);
    int ar, br, r;
    ar = a % 11;
    br = b % 11;
    if (!op) r = (ar + br) % 11;
    else     r = (ar - br + 22) % 11;
    return 4'(r);
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // drive one operation, queue its expected result, compare one edge later
  task automatic op(input string tag, input logic rn, input logic sv,
                    input logic [3:0] xv, input logic [3:0] yv, input logic [3:0] exp);
    exp_t e;
    rst_n = rn;
    s     = sv;
    x     = xv;
    y     = yv;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 4'hF, 4'h0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, z, e.exp);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    s       = 1'b0;
    x       = 4'd0;
    y       = 4'd0;
    @(negedge clk);

    op("reset_state", 1'b0, 1'b1, 4'd10, 4'd3, 4'd0);

    op("add_wrap_7p9",   1'b1, 1'b0, 4'd7,  4'd9,  4'd5);
    op("sub_borrow_3m8", 1'b1, 1'b1, 4'd3,  4'd8,  4'd6);
    op("sub_borrow_0m1", 1'b1, 1'b1, 4'd0,  4'd1,  4'd10);
    op("add_max_10p10",  1'b1, 1'b0, 4'd10, 4'd10, 4'd9);
    op("sub_zero_5m5",   1'b1, 1'b1, 4'd5,  4'd5,  4'd0);
    op("add_oor_13p4",   1'b1, 1'b0, 4'd13, 4'd4,  4'd6);
    op("sub_oor_15m4",   1'b1, 1'b1, 4'd15, 4'd4,  4'd0);
    op("add_10p1",       1'b1, 1'b0, 4'd10, 4'd1,  4'd0);
    op("sub_0m10",       1'b1, 1'b1, 4'd0,  4'd10, 4'd1);
    op("add_oor_15p15",  1'b1, 1'b0, 4'd15, 4'd15, 4'd8);
    op("sub_oor_11m12",  1'b1, 1'b1, 4'd11, 4'd12, 4'd10);

    // glitch on rst_n between edges must not disturb Z
    op("pre_glitch", 1'b1, 1'b0, 4'd2, 4'd3, 4'd5);
    #2 rst_n = 1'b0;
    #1 check("async_glitch_low", z, 4'd5);
    #1 rst_n = 1'b1;
    #1 check("async_glitch_high", z, 4'd5);
    @(negedge clk);

    // mid-stream reset discards the pending result, then release
    op("pre_reset",      1'b1, 1'b1, 4'd9, 4'd2, 4'd7);
    op("reset_9p9",      1'b0, 1'b0, 4'd9, 4'd9, 4'd0);
    op("reset_hold",     1'b0, 1'b1, 4'd4, 4'd1, 4'd0);
    op("release_9p9",    1'b1, 1'b0, 4'd9, 4'd9, 4'd7);

    // back-to-back op switching, every cycle
    op("switch_add", 1'b1, 1'b0, 4'd6, 4'd6, 4'd1);
    op("switch_sub", 1'b1, 1'b1, 4'd6, 4'd7, 4'd10);
    op("switch_add2", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);

    // exhaustive in-range sweep against the reference
    for (int sv = 0; sv < 2; sv++) begin
      for (int xv = 0; xv <= 10; xv++) begin
        for (int yv = 0; yv <= 10; yv++) begin
          op($sformatf("exh_s%0d_x%0d_y%0d", sv, xv, yv), 1'b1, 1'(sv),
             4'(xv), 4'(yv), ref_mod(1'(sv), xv, yv));
        end
      end
    end

    // out-of-range operand sweep
    for (int sv = 0; sv < 2; sv++) begin
      for (int xv = 11; xv <= 15; xv++) begin
        for (int yv = 0; yv <= 15; yv += 3) begin
          op($sformatf("oor_s%0d_x%0d_y%0d", sv, xv, yv), 1'b1, 1'(sv),
             4'(xv), 4'(yv), ref_mod(1'(sv), xv, yv));
        end
      end
    end

    check("sb_empty", 4'(sb_q.size()), 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 The block SHALL have no parameters; modulus 11 and operand width 4 are fixed.
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-004 The block SHALL have port s, input, 1 bit, operation select: 0 = add, 1 = subtract.
REQ-005 The block SHALL have ports x3, x2, x1, x0, inputs, 1 bit each, operand X, x3 = MSB (weight 8), x0 = LSB.
REQ-006 The block SHALL have ports y3, y2, y1, y0, inputs, 1 bit each, operand Y, same bit weighting as X.
REQ-007 The block SHALL have ports z3, z2, z1, z0, outputs, 1 bit each, result Z, z3 = MSB, always in range 0..10.

Function
REQ-008 X and Y SHALL each be interpreted as unsigned 4-bit values.
REQ-009 Operand reduction: any operand value 11..15 SHALL be reduced to value-11 (0..4) before the operation; values 0..10 SHALL pass unchanged.
REQ-010 With s=0, result SHALL be (Xr + Yr) mod 11: 5-bit sum; if sum >= 11, subtract 11.
REQ-011 With s=1, result SHALL be (Xr - Yr) mod 11 as a non-negative residue: if Xr >= Yr, Xr-Yr; otherwise Xr-Yr+11.
REQ-012 The datapath SHALL be combinational from inputs to a single 4-bit output register; Z SHALL update on every rising clk edge with rst_n=1.
REQ-013 Latency SHALL be exactly 1 clock: inputs stable before edge N produce the result on Z immediately after edge N.
REQ-014 The block SHALL have no handshake and no enable; a new operation is accepted every cycle (throughput 1/cycle).
REQ-015 Z SHALL never hold a value 11..15 in any cycle, including the first cycle after reset.
REQ-016 Boundary behaviour: 10+10 -> 9; 10+1 -> 0; 0-1 -> 10; 0-10 -> 1; x-x -> 0 for all x.
REQ-017 Changing s between cycles SHALL take effect on the next edge with no residual state; the block holds no state other than Z.

Reset
REQ-018 When rst_n=0 at a rising clk edge, z3..z0 SHALL be 0000 after that edge, regardless of s, X, Y.
REQ-019 Reset SHALL NOT act asynchronously; a rst_n pulse between edges SHALL have no effect on Z.
REQ-020 On the first edge with rst_n=1, Z SHALL take the result of the inputs present at that edge.
REQ-021 Reset asserted mid-stream SHALL discard the pending result; Z = 0000 until the first edge with rst_n released.

Verification
REQ-022 Add wrap case: s=0, X=7, Y=9 -> Z=5 (0101) one edge later.
REQ-023 Subtract borrow case: s=1, X=3, Y=8 -> Z=6 (0110); s=1, X=0, Y=1 -> Z=10 (1010).
REQ-024 Maximum and zero cases: s=0, X=10, Y=10 -> Z=9 (1001); s=1, X=5, Y=5 -> Z=0 (0000).
REQ-025 Out-of-range operand case: s=0, X=13, Y=4 -> Z=6 (0110); s=1, X=15, Y=4 -> Z=0 (0000).
REQ-026 Reset case: rst_n=0 for one edge with s=0, X=9, Y=9 -> Z=0000; then rst_n=1 -> Z=7 (0111).
REQ-027 Exhaustive case: all s in {0,1}, X and Y in 0..10 (242 operations), one result per cycle -> all 242 match the reference modular result.
